// File: rtl/acc_history_pkg.sv
// Shared action encoding and button-priority decode for the calculator accumulator.
package calc_pkg;

    typedef enum logic [1:0] {
        ACT_NONE,
        ACT_CLEAR,
        ACT_COMMIT,
        ACT_UNDO
    } action_e;

    // Coincident pulses resolve clear > commit > undo; losers are dropped.
    function automatic action_e prio_encode(input logic clr, input logic cmt, input logic und);
        if (clr) begin
            return ACT_CLEAR;
        end else if (cmt) begin
            return ACT_COMMIT;
        end else if (und) begin
            return ACT_UNDO;
        end
        return ACT_NONE;
    endfunction

endpackage

// File: rtl/acc_history_if.sv
// Button, ALU and accumulator/history status signals of the accumulator block.
interface acc_history_if #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 8
);
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic             btnac;
    logic             btnc;
    logic             btnu;
    logic [WIDTH-1:0] alu_result;
    logic [WIDTH-1:0] acc;
    logic [CNT_W-1:0] hist_count;
    logic             hist_full;
    logic             hist_empty;
    logic             undo_err;

    modport master (
        output btnac, btnc, btnu, alu_result,
        input  acc, hist_count, hist_full, hist_empty, undo_err
    );

    modport slave (
        input  btnac, btnc, btnu, alu_result,
        output acc, hist_count, hist_full, hist_empty, undo_err
    );
endinterface

// File: rtl/acc_history_btn_pulse.sv
// Raw button conditioner: 2-FF synchroniser, debounce counter and rising-edge
// pulse generator.
module btn_pulse #(
    parameter int DB_CYCLES = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic raw,
    output logic pulse
);
    localparam int CW = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(DB_CYCLES - 1);

    logic          sync1_q, sync2_q;
    logic          level_q, level_d;
    logic          level_dly_q;
    logic          pulse_q, pulse_d;
    logic [CW-1:0] cnt_q, cnt_d;

    // Level flips only after the synchronised input has disagreed for DB_CYCLES cycles.
    always_comb begin
        level_d = level_q;
        cnt_d   = '0;
        if (sync2_q != level_q) begin
            if (cnt_q == CNT_LAST) begin
                level_d = sync2_q;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
        pulse_d = level_q & ~level_dly_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q     <= 1'b0;
            sync2_q     <= 1'b0;
            level_q     <= 1'b0;
            level_dly_q <= 1'b0;
            cnt_q       <= '0;
            pulse_q     <= 1'b0;
        end else begin
            sync1_q     <= raw;
            sync2_q     <= sync1_q;
            level_q     <= level_d;
            level_dly_q <= level_q;
            cnt_q       <= cnt_d;
            pulse_q     <= pulse_d;
        end
    end

    assign pulse = pulse_q;
endmodule

// File: rtl/acc_history.sv
// Calculator accumulator with commit/clear/undo buttons and a circular undo
// history that overwrites its oldest entry when full.
module acc_history
    import calc_pkg::*;
#(
    parameter int WIDTH     = 16,
    parameter int DEPTH     = 8,
    parameter int DB_CYCLES = 4
) (
    input  logic          clk,
    input  logic          rst,
    acc_history_if.slave  bus
);
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(DEPTH - 1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);

    logic clr_pulse, cmt_pulse, und_pulse;

    btn_pulse #(.DB_CYCLES(DB_CYCLES)) u_clr (.clk(clk), .rst(rst), .raw(bus.btnac), .pulse(clr_pulse));
    btn_pulse #(.DB_CYCLES(DB_CYCLES)) u_cmt (.clk(clk), .rst(rst), .raw(bus.btnc),  .pulse(cmt_pulse));
    btn_pulse #(.DB_CYCLES(DB_CYCLES)) u_und (.clk(clk), .rst(rst), .raw(bus.btnu),  .pulse(und_pulse));

    action_e          act;
    logic [WIDTH-1:0] hist_q [DEPTH];
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [PTR_W-1:0] top_q, top_d, top_inc, top_dec;
    logic [CNT_W-1:0] count_q, count_d;
    logic             full_q, full_d;
    logic             empty_q, empty_d;
    logic             undo_err_q, undo_err_d;
    logic             push;

    assign act = prio_encode(clr_pulse, cmt_pulse, und_pulse);

    // Pointer wrap is explicit so DEPTH need not be a power of two.
    assign top_inc = (top_q == PTR_LAST) ? '0 : top_q + 1'b1;
    assign top_dec = (top_q == '0) ? PTR_LAST : top_q - 1'b1;

    always_comb begin
        acc_d      = acc_q;
        top_d      = top_q;
        count_d    = count_q;
        undo_err_d = 1'b0;
        push       = 1'b0;
        case (act)
            ACT_CLEAR: begin
                push  = 1'b1;
                acc_d = '0;
            end
            ACT_COMMIT: begin
                push  = 1'b1;
                acc_d = bus.alu_result;
            end
            ACT_UNDO: begin
                if (count_q == '0) begin
                    undo_err_d = 1'b1;
                end else begin
                    top_d   = top_dec;
                    acc_d   = hist_q[top_dec];
                    count_d = count_q - 1'b1;
                end
            end
            default: ;
        endcase
        if (push) begin
            top_d   = top_inc;
            count_d = (count_q == CNT_FULL) ? count_q : count_q + 1'b1;
        end
        full_d  = (count_d == CNT_FULL);
        empty_d = (count_d == '0);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            acc_q      <= '0;
            top_q      <= '0;
            count_q    <= '0;
            full_q     <= 1'b0;
            empty_q    <= 1'b1;
            undo_err_q <= 1'b0;
        end else begin
            acc_q      <= acc_d;
            top_q      <= top_d;
            count_q    <= count_d;
            full_q     <= full_d;
            empty_q    <= empty_d;
            undo_err_q <= undo_err_d;
        end
    end

    // History storage is data only; entries beyond hist_count are never read.
    always_ff @(posedge clk) begin
        if (push && !rst) begin
            hist_q[top_q] <= acc_q;
        end
    end

    assign bus.acc        = acc_q;
    assign bus.hist_count = count_q;
    assign bus.hist_full  = full_q;
    assign bus.hist_empty = empty_q;
    assign bus.undo_err   = undo_err_q;
endmodule

// File: tb/tb_acc_history.sv
// Directed bench for acc_history with WIDTH=16, DEPTH=4, DB_CYCLES=2.
module tb_acc_history;
    localparam int W  = 16;
    localparam int D  = 4;
    localparam int DB = 2;

    logic clk = 1'b0;
    logic rst;
    int   n_cmp = 0;
    int   n_err = 0;
    int   err_pulses;

    always #5 clk = ~clk;

    acc_history_if #(.WIDTH(W), .DEPTH(D)) bus ();

    acc_history #(.WIDTH(W), .DEPTH(D), .DB_CYCLES(DB)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // m = {clear, commit, undo}; holds for 'hold' cycles then lets everything settle.
    task automatic press(input logic [2:0] m, input int hold);
        err_pulses = 0;
        bus.btnac = m[2];
        bus.btnc  = m[1];
        bus.btnu  = m[0];
        repeat (hold) begin
            @(negedge clk);
            if (bus.undo_err) err_pulses++;
        end
        bus.btnac = 1'b0;
        bus.btnc  = 1'b0;
        bus.btnu  = 1'b0;
        repeat (14) begin
            @(negedge clk);
            if (bus.undo_err) err_pulses++;
        end
    endtask

    task automatic commit(input logic [15:0] v);
        bus.alu_result = v;
        press(3'b010, 4);
    endtask

    task automatic do_reset();
        bus.btnac = 1'b0;
        bus.btnc  = 1'b0;
        bus.btnu  = 1'b0;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        bus.alu_result = '0;
        @(negedge clk);
        do_reset();

        // Reset state and undo on empty history
        chk("rst_acc",   32'(bus.acc), 32'h0);
        chk("rst_cnt",   32'(bus.hist_count), 32'd0);
        chk("rst_empty", 32'(bus.hist_empty), 32'd1);
        chk("rst_full",  32'(bus.hist_full), 32'd0);
        chk("rst_uerr",  32'(bus.undo_err), 32'd0);
        press(3'b001, 4);
        chk("empty_undo_pulses", 32'(err_pulses), 32'd1);
        chk("empty_undo_acc",    32'(bus.acc), 32'h0);

        // Commit latency: raw edge first sampled at edge k, acc updates at k+5
        bus.alu_result = 16'h1234;
        bus.btnc = 1'b1;
        @(posedge clk);
        repeat (4) @(posedge clk);
        #1;
        chk("lat_k4_acc", 32'(bus.acc), 32'h0);
        @(posedge clk);
        #1;
        chk("lat_k5_acc", 32'(bus.acc), 32'h1234);
        chk("lat_k5_cnt", 32'(bus.hist_count), 32'd1);
        bus.alu_result = 16'hBEEF;
        repeat (5) @(negedge clk);
        bus.btnc = 1'b0;
        repeat (14) @(negedge clk);
        chk("hold_once_acc", 32'(bus.acc), 32'h1234);
        chk("hold_once_cnt", 32'(bus.hist_count), 32'd1);

        // Glitch filtering
        bus.alu_result = 16'h0055;
        press(3'b010, 1);
        chk("glitch1_acc", 32'(bus.acc), 32'h1234);
        chk("glitch1_cnt", 32'(bus.hist_count), 32'd1);
        press(3'b010, 3);
        chk("glitch3_acc", 32'(bus.acc), 32'h0055);
        chk("glitch3_cnt", 32'(bus.hist_count), 32'd2);

        // Overwrite oldest entry when full, then unwind
        do_reset();
        commit(16'd1); chk("c1_cnt", 32'(bus.hist_count), 32'd1);
        commit(16'd2); chk("c2_cnt", 32'(bus.hist_count), 32'd2);
        commit(16'd3); chk("c3_cnt", 32'(bus.hist_count), 32'd3);
        chk("c3_full", 32'(bus.hist_full), 32'd0);
        commit(16'd4); chk("c4_full", 32'(bus.hist_full), 32'd1);
        commit(16'd5);
        chk("c5_acc",  32'(bus.acc), 32'd5);
        chk("c5_cnt",  32'(bus.hist_count), 32'd4);
        chk("c5_full", 32'(bus.hist_full), 32'd1);
        press(3'b001, 4); chk("u1_acc", 32'(bus.acc), 32'd4); chk("u1_cnt", 32'(bus.hist_count), 32'd3);
        chk("u1_full", 32'(bus.hist_full), 32'd0);
        press(3'b001, 4); chk("u2_acc", 32'(bus.acc), 32'd3); chk("u2_cnt", 32'(bus.hist_count), 32'd2);
        press(3'b001, 4); chk("u3_acc", 32'(bus.acc), 32'd2); chk("u3_cnt", 32'(bus.hist_count), 32'd1);
        press(3'b001, 4); chk("u4_acc", 32'(bus.acc), 32'd1); chk("u4_cnt", 32'(bus.hist_count), 32'd0);
        chk("u4_empty", 32'(bus.hist_empty), 32'd1);
        chk("u4_err",   32'(err_pulses), 32'd0);
        press(3'b001, 4);
        chk("u5_err", 32'(err_pulses), 32'd1);
        chk("u5_acc", 32'(bus.acc), 32'd1);

        // Clear beats commit when both rise together; clear is undoable
        do_reset();
        commit(16'h00FF);
        chk("pre_clr_cnt", 32'(bus.hist_count), 32'd1);
        bus.alu_result = 16'hAAAA;
        press(3'b110, 4);
        chk("clr_acc", 32'(bus.acc), 32'h0);
        chk("clr_cnt", 32'(bus.hist_count), 32'd2);
        press(3'b001, 4);
        chk("clr_undo_acc", 32'(bus.acc), 32'h00FF);
        chk("clr_undo_cnt", 32'(bus.hist_count), 32'd1);

        // Reset mid-debounce, button released during reset
        do_reset();
        commit(16'h000A); commit(16'h000B); commit(16'h000C);
        chk("pre_rst_cnt", 32'(bus.hist_count), 32'd3);
        bus.alu_result = 16'h000D;
        bus.btnc = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("mid_rst_acc",   32'(bus.acc), 32'h0);
        chk("mid_rst_cnt",   32'(bus.hist_count), 32'd0);
        chk("mid_rst_empty", 32'(bus.hist_empty), 32'd1);
        chk("mid_rst_full",  32'(bus.hist_full), 32'd0);
        chk("mid_rst_uerr",  32'(bus.undo_err), 32'd0);
        bus.btnc = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        repeat (14) @(negedge clk);
        chk("rel_rst_acc", 32'(bus.acc), 32'h0);
        chk("rel_rst_cnt", 32'(bus.hist_count), 32'd0);

        // Reset mid-debounce, button held through reset: one fresh commit
        commit(16'h000A); commit(16'h000B); commit(16'h000C);
        bus.alu_result = 16'h000D;
        bus.btnc = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        repeat (4) @(posedge clk);
        #1;
        chk("held_k4_acc", 32'(bus.acc), 32'h0);
        @(posedge clk);
        #1;
        chk("held_k5_acc", 32'(bus.acc), 32'h000D);
        chk("held_k5_cnt", 32'(bus.hist_count), 32'd1);
        repeat (6) @(negedge clk);
        bus.btnc = 1'b0;
        repeat (14) @(negedge clk);
        chk("held_once_acc", 32'(bus.acc), 32'h000D);
        chk("held_once_cnt", 32'(bus.hist_count), 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed no completion expected finish within 200000 ns");
        $fatal(1, "watchdog");
    end
endmodule
